eka_mem_arbiter: RTL and testbench
==================================

EKA_MEM_ARBITER -- requirements
Module: eka_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of all address buses.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4: consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch request; held high until if_gnt.
REQ-006 SHALL have port if_addr, input, ADDR_WIDTH: fetch address.
REQ-007 SHALL have port if_gnt, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid, output, 1: one-cycle pulse; fetch complete; if_rdata valid.
REQ-009 SHALL have port if_rdata, output, 32: fetched instruction.
REQ-010 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDR_WIDTH) and d_wdata (input, 32): data request, write-enable, address and write data; d_req held until d_gnt.
REQ-011 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, 32): data grant, completion pulse and read data.
REQ-012 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_WIDTH) and mem_wdata (output, 32): shared memory port request.
REQ-013 SHALL have ports mem_ack (input, 1) and mem_rdata (input, 32): memory completion and read data, valid in the mem_ack cycle.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, IF_BUSY and D_BUSY.
REQ-016 In IDLE, a grant SHALL be combinational: at most one of if_gnt/d_gnt high; neither is asserted outside IDLE.
REQ-017 Priority SHALL be data over fetch, except fetch wins when both requests are present and streak == MAX_D_STREAK.
REQ-018 streak (width clog2(MAX_D_STREAK+1)) SHALL increment on a d_gnt while if_req is high and saturate at MAX_D_STREAK; it clears on any if_gnt and on a d_gnt with if_req low.
REQ-019 On a grant, the block SHALL latch addr, we (0 for fetch) and wdata (0 for fetch) into internal registers and enter IF_BUSY or D_BUSY at the next edge.
REQ-020 In IF_BUSY/D_BUSY, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from the latched registers, stable until mem_ack.
REQ-021 On mem_ack in a BUSY state, the FSM SHALL return to IDLE at that edge, and the owner's rvalid SHALL pulse for exactly the next cycle with rdata = registered mem_rdata (0 for writes).
REQ-022 The minimum latency SHALL be: grant at cycle N, mem_req at N+1, ack at N+1 gives rvalid at N+2; a new grant is possible in cycle N+2 (the same cycle as rvalid).
REQ-023 mem_ack in IDLE SHALL be ignored, with no rvalid and no state change.
REQ-024 Only one transaction SHALL be outstanding; requests arriving while busy wait, and if_addr/d_* changes during a BUSY state have no effect.
REQ-025 if_rdata/d_rdata SHALL hold their last value when not valid.

Reset
REQ-026 While reset is high at the clock edge: state=IDLE, streak=0, latched registers=0, rdata registers=0.
REQ-027 During and after reset: mem_req=0, mem_we=0, if_rvalid=0, d_rvalid=0, busy=0; if_gnt/d_gnt are not asserted in a cycle in which reset is high.
REQ-028 Reset mid-transaction SHALL abandon the transaction: no rvalid, and a later mem_ack for it is ignored per REQ-023.

Structure
REQ-029 A shared package eka_pkg SHALL hold the state enum arb_state_t (IDLE, IF_BUSY, D_BUSY) and the constant EKA_XLEN=32.
REQ-030 No sub-module SHALL be used; the grant/priority logic is a single combinational process alongside the FSM.

Verification
REQ-031 Fetch read: if_req=1, if_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_req/mem_addr=0x100 at cycle 1, if_rvalid=1 with if_rdata=0x00500093 at cycle 2.
REQ-032 Data write: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> mem_we=1 and stable address/data for 4 cycles, then a single d_rvalid pulse with d_rdata=0.
REQ-033 Contention: if_req and d_req held continuously, single-cycle acks -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
REQ-034 Simultaneous: both requests first asserted in the same IDLE cycle with streak=0 -> d_gnt=1 and if_gnt=0.
REQ-035 Reset in D_BUSY, then mem_ack the cycle after reset deasserts -> mem_req=0 and busy=0, no d_rvalid, state IDLE.
REQ-036 Spurious mem_ack=1 in IDLE with no requests -> all outputs remain 0.

Source files
------------

// File: rtl/eka_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eka_pkg
//  Description : Shared types and constants for the EKA memory arbiter.
//                - arb_state_t : arbiter FSM state encoding
//                - EKA_XLEN    : data path width (instruction / data word)
//  Revision    : 1.0 - initial release
// ============================================================================
package eka_pkg;

    localparam int EKA_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

endpackage : eka_pkg
`default_nettype wire

// File: rtl/eka_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : eka_mem_arbiter
//  Description : Two-master arbiter sharing one memory port between an
//                instruction-fetch master and a data master. One transaction
//                is outstanding at a time. Data has priority, but after
//                MAX_D_STREAK consecutive data grants taken while fetch was
//                waiting, fetch wins the next arbitration.
//
//  Ports
//    clk, reset                : clock, synchronous active-high reset
//    if_req/if_addr            : fetch request (held until if_gnt)
//    if_gnt/if_rvalid/if_rdata : fetch grant, completion pulse, read data
//    d_req/d_we/d_addr/d_wdata : data request (held until d_gnt)
//    d_gnt/d_rvalid/d_rdata    : data grant, completion pulse, read data
//    mem_req/mem_we/mem_addr/
//    mem_wdata                 : shared memory request
//    mem_ack/mem_rdata         : memory completion and read data
//    busy                      : transaction in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module eka_mem_arbiter
    import eka_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [EKA_XLEN-1:0]   if_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [EKA_XLEN-1:0]   d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [EKA_XLEN-1:0]   d_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [EKA_XLEN-1:0]   mem_wdata,
    input  logic                  mem_ack,
    input  logic [EKA_XLEN-1:0]   mem_rdata,

    output logic                  busy
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t              state_q;
    logic [STREAK_W-1:0]     streak_q;
    logic [STREAK_W-1:0]     streak_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [EKA_XLEN-1:0]     wdata_q;
    logic                    if_rvalid_q;
    logic                    d_rvalid_q;
    logic [EKA_XLEN-1:0]     if_rdata_q;
    logic [EKA_XLEN-1:0]     d_rdata_q;

    logic                    w_idle;
    logic                    w_fetch_turn;
    logic                    w_if_gnt;
    logic                    w_d_gnt;

    // ------------------------------------------------------------------
    // Grant / priority logic. Grants are combinational in IDLE so a new
    // transaction can start in the same cycle the previous rvalid pulses.
    // Grants are suppressed while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_idle       = (state_q == IDLE);
        // Fetch has been starved long enough: it wins this arbitration.
        w_fetch_turn = if_req && (streak_q == C_STREAK_MAX);
        w_d_gnt      = w_idle && !reset && d_req && !w_fetch_turn;
        w_if_gnt     = w_idle && !reset && if_req && !w_d_gnt;

        streak_d = streak_q;
        if (w_if_gnt) begin
            streak_d = '0;
        end else if (w_d_gnt) begin
            if (if_req) begin
                // Count only data wins that made fetch wait; saturate.
                streak_d = (streak_q == C_STREAK_MAX) ? C_STREAK_MAX
                                                      : streak_q + STREAK_W'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered request latches and completion outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            // Completion strobes are single-cycle pulses.
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            streak_q    <= streak_d;

            case (state_q)
                IDLE: begin
                    // mem_ack here belongs to nobody and is dropped.
                    if (w_if_gnt) begin
                        state_q <= IF_BUSY;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end else if (w_d_gnt) begin
                        state_q <= D_BUSY;
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        wdata_q <= d_wdata;
                    end
                end

                IF_BUSY: begin
                    if (mem_ack) begin
                        state_q     <= IDLE;
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                end

                D_BUSY: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        d_rvalid_q <= 1'b1;
                        // Writes return no data.
                        d_rdata_q  <= we_q ? '0 : mem_rdata;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Control outputs are forced low while reset is asserted so
    // an abandoned transaction never shows on the memory port.
    // ------------------------------------------------------------------
    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign busy      = !reset && !w_idle;
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = !reset && if_rvalid_q;
    assign d_rvalid  = !reset && d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule : eka_mem_arbiter
`default_nettype wire

// File: tb/tb_eka_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eka_mem_arbiter
//  Description : Directed self-checking bench for eka_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eka_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eka_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven and outputs sampled
    // well away from the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit [9:0] pat;
        bit       is_d;
        bit       prev_d;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        pat = 10'b1111011110;
        prev_d = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1;
        #1;
        chk("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
        chk("rst_d_gnt",     {31'd0, d_gnt},     32'd0);
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        chk("rst_if_rdata",  if_rdata,           32'd0);
        chk("rst_d_rdata",   d_rdata,            32'd0);
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

        // ---------------- fetch read ----------------
        step();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk("fr_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fr_d_gnt",  {31'd0, d_gnt},  32'd0);
        step();
        if_req = 1'b0; if_addr = 32'hFFF0; mem_ack = 1'b1; mem_rdata = 32'h00500093;
        #1;
        chk("fr_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("fr_mem_addr", mem_addr,         32'h100);
        chk("fr_mem_we",   {31'd0, mem_we},  32'd0);
        chk("fr_busy",     {31'd0, busy},    32'd1);
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("fr_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fr_if_rdata",  if_rdata,           32'h00500093);
        chk("fr_busy_done", {31'd0, busy},      32'd0);
        chk("fr_mem_req_0", {31'd0, mem_req},   32'd0);
        step();
        #1;
        chk("fr_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);
        chk("fr_rdata_hold",   if_rdata,           32'h00500093);

        // ---------------- spurious ack in IDLE ----------------
        mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        step(); step();
        #1;
        chk("sp_busy",      {31'd0, busy},      32'd0);
        chk("sp_mem_req",   {31'd0, mem_req},   32'd0);
        chk("sp_mem_we",    {31'd0, mem_we},    32'd0);
        chk("sp_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("sp_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        chk("sp_if_gnt",    {31'd0, if_gnt},    32'd0);
        chk("sp_d_gnt",     {31'd0, d_gnt},     32'd0);
        chk("sp_if_rdata",  if_rdata,           32'h00500093);
        mem_ack = 1'b0;
        step();

        // ------- simultaneous first request, then sustained contention -------
        for (int i = 0; i < 10; i++) begin
            is_d = pat[9-i];
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ack = 1'b0;
            if_addr = 32'h100 + 32'(i * 4);
            d_addr  = 32'h400 + 32'(i * 4);
            #1;
            chk($sformatf("ct%0d_d_gnt", i),  {31'd0, d_gnt},  {31'd0, is_d});
            chk($sformatf("ct%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, !is_d});
            if (i > 0) begin
                chk($sformatf("ct%0d_prev_rvalid", i),
                    {31'd0, (prev_d ? d_rvalid : if_rvalid)}, 32'd1);
                chk($sformatf("ct%0d_prev_rdata", i),
                    (prev_d ? d_rdata : if_rdata), 32'hC0DE0000 + 32'(i - 1));
            end
            step();
            mem_ack = 1'b1; mem_rdata = 32'hC0DE0000 + 32'(i);
            #1;
            chk($sformatf("ct%0d_mem_addr", i), mem_addr,
                is_d ? 32'h400 + 32'(i * 4) : 32'h100 + 32'(i * 4));
            prev_d = is_d;
            step();
        end
        mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        chk("ct_last_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("ct_last_if_rdata",  if_rdata,           32'hC0DE0009);
        chk("ct_d_rdata_hold",   d_rdata,            32'hC0DE0008);
        step();

        // ---------------- data write with 3 wait cycles ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_d_gnt",  {31'd0, d_gnt},  32'd1);
        chk("wr_if_gnt", {31'd0, if_gnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            d_req = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_we = 1'b0;
            mem_rdata = 32'h12345678; mem_ack = (i == 3);
            #1;
            chk($sformatf("wr%0d_mem_req", i),   {31'd0, mem_req},  32'd1);
            chk($sformatf("wr%0d_mem_we", i),    {31'd0, mem_we},   32'd1);
            chk($sformatf("wr%0d_mem_addr", i),  mem_addr,          32'h2000);
            chk($sformatf("wr%0d_mem_wdata", i), mem_wdata,         32'hDEADBEEF);
            chk($sformatf("wr%0d_d_rvalid", i),  {31'd0, d_rvalid}, 32'd0);
        end
        step();
        mem_ack = 1'b0;
        #1;
        chk("wr_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("wr_d_rdata",  d_rdata,           32'd0);
        chk("wr_busy",     {31'd0, busy},     32'd0);
        step();
        #1;
        chk("wr_rvalid_pulse", {31'd0, d_rvalid}, 32'd0);

        // ---------------- reset in D_BUSY ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #1;
        chk("rb_d_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0; reset = 1'b1;
        #1;
        chk("rb_mem_req_in_rst", {31'd0, mem_req}, 32'd0);
        chk("rb_busy_in_rst",    {31'd0, busy},    32'd0);
        step();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99;
        #1;
        chk("rb_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rb_busy",    {31'd0, busy},    32'd0);
        chk("rb_d_rdata", d_rdata,          32'd0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("rb_d_rvalid",   {31'd0, d_rvalid}, 32'd0);
        chk("rb_busy_after", {31'd0, busy},     32'd0);
        chk("rb_mem_req_2",  {31'd0, mem_req},  32'd0);
        chk("rb_d_rdata_2",  d_rdata,           32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_eka_mem_arbiter
`default_nettype wire
